// File: rtl/nb_pkg.sv
// nb_pkg: shared definitions for the boot-time instruction loader.
//   NOP_INSN       - filler word written into unused imem locations (ADDI x0,x0,0)
//   IMEM_DEPTH     - default instruction memory depth in 32-bit words
//   loader_state_t - loader FSM state encoding
package nb_pkg;

  localparam logic [31:0] NOP_INSN   = 32'h0000_0013;
  localparam int          IMEM_DEPTH = 2048;

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    FILL = 3'd3,
    RUN  = 3'd4,
    ERR  = 3'd5
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles four little-endian bytes into one 32-bit word.
//   clk, rst_n  - clock and asynchronous active-low reset (discards a partial word)
//   push        - a payload byte is accepted this cycle
//   data        - the payload byte
//   word_valid  - high for the cycle in which the 4th byte of a word is pushed
//   word        - completed word, valid together with word_valid
module byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic [7:0]  data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  idx;
  logic [31:0] sr;

  // Byte k of a word is stored straight into lane k, so no reordering is
  // needed when the word completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      sr  <= '0;
    end else if (push) begin
      idx                   <= idx + 2'd1;
      sr[{idx, 3'b000} +: 8] <= data;
    end
  end

  // The completed word is presented in the same cycle as its 4th byte so the
  // loader can register the write on that handshake edge; the lane being
  // pushed is taken from the input rather than from the not-yet-updated sr.
  always_comb begin
    word                     = sr;
    word[{idx, 3'b000} +: 8] = data;
    word_valid               = push && (idx == 2'd3);
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader in front of the single-cycle CPU.
// Receives a byte stream (2-byte little-endian word count N, then N
// little-endian 32-bit words), writes the words to imem, fills the remaining
// locations with NOP and then releases the CPU from reset.
//   clk, rst_n   - clock and asynchronous active-low reset
//   in_valid     - byte-stream valid
//   in_data      - byte-stream data
//   in_ready     - loader accepts a byte this cycle (state-derived, registered)
//   imem_we      - imem write strobe, one word per asserted cycle
//   imem_addr    - imem word address
//   imem_wdata   - imem write data
//   cpu_rst_n    - active-low CPU reset, released once the image is complete
//   done         - image written and CPU released
//   err          - illegal header (N==0 or N>DEPTH); locked until rst_n
module imem_loader
  import nb_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  localparam logic [16:0] DEPTH_W17 = 17'(DEPTH);
  localparam logic [15:0] DEPTH_W16 = 16'(DEPTH);
  localparam logic [15:0] LAST_ADDR = 16'(DEPTH - 1);

  loader_state_t state, next_state;

  logic [7:0]  count_lo, next_count_lo;
  logic [15:0] count, next_count;
  logic [15:0] word_cnt, next_word_cnt;
  logic [15:0] hdr_n;
  logic        accept;
  logic        push;
  logic        word_valid;
  logic [31:0] word;
  logic        wr_en;
  logic [31:0] wr_data;

  // in_ready is a registered copy of "state accepts bytes", so the handshake
  // never depends combinationally on in_valid.
  assign accept = in_valid && in_ready;
  assign push   = accept && (state == DATA);
  assign hdr_n  = {in_data, count_lo};

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .data       (in_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // State register plus all registered outputs. done/cpu_rst_n follow the
  // RUN state one cycle late so they rise the cycle after the final write;
  // err and in_ready follow the next state so they change right after the
  // handshake that causes the transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HDR0;
      count_lo   <= '0;
      count      <= '0;
      word_cnt   <= '0;
      in_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_rst_n  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state     <= next_state;
      count_lo  <= next_count_lo;
      count     <= next_count;
      word_cnt  <= next_word_cnt;
      in_ready  <= (next_state == HDR0) || (next_state == HDR1) ||
                   (next_state == DATA);
      imem_we   <= wr_en;
      if (wr_en) begin
        imem_addr  <= word_cnt[ADDR_W-1:0];
        imem_wdata <= wr_data;
      end
      cpu_rst_n <= (state == RUN);
      done      <= (state == RUN);
      err       <= (next_state == ERR);
    end
  end

  // Next-state logic and the write mux (packer word in DATA, NOP in FILL).
  // The word counter doubles as the write address for both phases, so FILL
  // continues seamlessly from address N.
  always_comb begin
    next_state    = state;
    next_count_lo = count_lo;
    next_count    = count;
    next_word_cnt = word_cnt;
    wr_en         = 1'b0;
    wr_data       = NOP_INSN;

    case (state)
      HDR0: begin
        if (accept) begin
          next_count_lo = in_data;
          next_state    = HDR1;
        end
      end

      HDR1: begin
        if (accept) begin
          next_count    = hdr_n;
          next_word_cnt = '0;
          if ((hdr_n == 16'd0) || ({1'b0, hdr_n} > DEPTH_W17)) begin
            next_state = ERR;
          end else begin
            next_state = DATA;
          end
        end
      end

      DATA: begin
        if (word_valid) begin
          wr_en         = 1'b1;
          wr_data       = word;
          next_word_cnt = word_cnt + 16'd1;
          if (word_cnt == count - 16'd1) begin
            next_state = (count == DEPTH_W16) ? RUN : FILL;
          end
        end
      end

      FILL: begin
        wr_en         = 1'b1;
        wr_data       = NOP_INSN;
        next_word_cnt = word_cnt + 16'd1;
        if (word_cnt == LAST_ADDR) begin
          next_state = RUN;
        end
      end

      RUN: begin
        next_state = RUN;
      end

      ERR: begin
        next_state = ERR;
      end

      default: begin
        next_state = HDR0;
      end
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader (DEPTH=2048).
// A negedge monitor keeps a model of imem built from the write strobes;
// header legality is checked from a vector table, full loads and reset
// corner cases by hand-written sequences.
module tb_imem_loader;

  localparam int          DEPTH  = 2048;
  localparam int          ADDR_W = 11;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  int total = 0;
  int bad   = 0;

  logic [31:0]       mem [DEPTH];
  int                wcyc [DEPTH];
  int                cyc = 0;
  int                writes = 0;
  int                nop_writes = 0;
  int                last_wcyc = 0;
  int                done_cyc = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  bit                done_seen = 1'b0;

  logic [31:0] img [8] = '{32'h00a00093, 32'h01400113, 32'h002081b3, 32'h40110233,
                           32'h0020f2b3, 32'h0020e333, 32'h0020c3b3, 32'h0020a433};

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    logic       exp_err;
  } hdr_vec_t;

  hdr_vec_t vecs [6];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Memory model and event timestamps, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) begin
      mem[imem_addr]  = imem_wdata;
      wcyc[imem_addr] = cyc;
      writes++;
      if (imem_wdata == NOP) nop_writes++;
      last_wcyc  = cyc;
      last_waddr = imem_addr;
    end
    if (done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]  = 'x;
      wcyc[i] = -1;
    end
    writes     = 0;
    nop_writes = 0;
    last_wcyc  = 0;
    done_seen  = 1'b0;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    clearModel();
    rst_n = 1'b1;
  endtask

  // Called and returns at a negedge; the byte transfers on the posedge between.
  task automatic sendByte(input logic [7:0] b, input bit gappy);
    int guard;
    if (gappy) begin
      while ($urandom_range(1, 0) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    guard    = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (in_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout: in_ready=%b, expected 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w, input bit gappy);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], gappy);
  endtask

  task automatic loadImage(input bit gappy);
    sendByte(8'h08, gappy);
    sendByte(8'h00, gappy);
    for (int w = 0; w < 8; w++) sendWord(img[w], gappy);
  endtask

  task automatic waitDone(input string name);
    int guard = 0;
    while (done !== 1'b1 && guard < 12000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    checkOutput({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic checkImage(input string name);
    int diff = 0;
    for (int i = 0; i < 8; i++) if (mem[i] !== img[i]) diff++;
    checkOutput({name, "_payload_wrong"}, diff, 0);
    diff = 0;
    for (int i = 8; i < DEPTH; i++) if (mem[i] !== NOP) diff++;
    checkOutput({name, "_fill_wrong"}, diff, 0);
    checkOutput({name, "_mem0"}, mem[0], 32'h00a00093);
    checkOutput({name, "_mem7"}, mem[7], 32'h0020a433);
    checkOutput({name, "_writes"}, writes, DEPTH);
    checkOutput({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd1);
    checkOutput({name, "_done_lag"}, done_cyc - last_wcyc, 1);
    checkOutput({name, "_fill_start_lag"}, wcyc[8] - wcyc[7], 1);
  endtask

  task automatic applyStimulus(input hdr_vec_t v);
    doReset();
    sendByte(v.lo, 1'b0);
    sendByte(v.hi, 1'b0);
  endtask

  initial begin
    int diff;
    int w0;
    int ready_seen;

    vecs[0] = '{lo: 8'h00, hi: 8'h00, exp_err: 1'b1};
    vecs[1] = '{lo: 8'h01, hi: 8'h08, exp_err: 1'b1};
    vecs[2] = '{lo: 8'hff, hi: 8'hff, exp_err: 1'b1};
    vecs[3] = '{lo: 8'h01, hi: 8'h00, exp_err: 1'b0};
    vecs[4] = '{lo: 8'h00, hi: 8'h08, exp_err: 1'b0};
    vecs[5] = '{lo: 8'hff, hi: 8'h07, exp_err: 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    clearModel();
    repeat (2) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);

    $display("[TB] header table");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("hdr%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
      checkOutput($sformatf("hdr%0d_in_ready", i), 32'(in_ready), 32'(!vecs[i].exp_err));
      checkOutput($sformatf("hdr%0d_cpu_rst_n", i), 32'(cpu_rst_n), 32'd0);
      checkOutput($sformatf("hdr%0d_writes", i), writes, 0);
    end

    $display("[TB] 8-word image, back-to-back");
    doReset();
    loadImage(1'b0);
    waitDone("b2b");
    checkImage("b2b");

    $display("[TB] 8-word image, random stalls");
    doReset();
    loadImage(1'b1);
    waitDone("gap");
    checkImage("gap");

    $display("[TB] full-depth image, no fill");
    doReset();
    sendByte(8'h00, 1'b0);
    sendByte(8'h08, 1'b0);
    for (int w = 0; w < DEPTH; w++) sendWord(32'hA500_0000 + 32'(w), 1'b0);
    waitDone("full");
    diff = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== 32'hA500_0000 + 32'(i)) diff++;
    checkOutput("full_words_wrong", diff, 0);
    checkOutput("full_writes", writes, DEPTH);
    checkOutput("full_nop_writes", nop_writes, 0);
    checkOutput("full_last_addr", 32'(last_waddr), 32'd2047);
    checkOutput("full_done_lag", done_cyc - last_wcyc, 1);

    $display("[TB] abort after 5 payload bytes, then reload");
    doReset();
    sendByte(8'h08, 1'b0);
    sendByte(8'h00, 1'b0);
    sendWord(img[0], 1'b0);
    sendByte(8'h13, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    checkOutput("abort_imem_we", 32'(imem_we), 32'd0);
    @(negedge clk);
    clearModel();
    rst_n = 1'b1;
    sendByte(8'h01, 1'b0);
    sendByte(8'h00, 1'b0);
    sendWord(32'hdeadbeef, 1'b0);
    waitDone("reload");
    checkOutput("reload_mem0", mem[0], 32'hdeadbeef);
    checkOutput("reload_mem1", mem[1], NOP);
    checkOutput("reload_writes", writes, DEPTH);

    $display("[TB] extra bytes after done");
    w0         = writes;
    ready_seen = 0;
    in_valid   = 1'b1;
    in_data    = 8'h55;
    repeat (20) begin
      @(negedge clk);
      if (in_ready !== 1'b0) ready_seen++;
    end
    in_valid = 1'b0;
    checkOutput("post_ready_cycles", ready_seen, 0);
    checkOutput("post_writes", writes - w0, 0);
    checkOutput("post_done", 32'(done), 32'd1);
    checkOutput("post_mem0", mem[0], 32'hdeadbeef);

    $display("[TB] asynchronous reset after done");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_done", 32'(done), 32'd0);
    checkOutput("async_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    @(negedge clk);
    clearModel();
    rst_n = 1'b1;

    $display("[TB] asynchronous reset during fill");
    sendByte(8'h01, 1'b0);
    sendByte(8'h00, 1'b0);
    sendWord(32'h11223344, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("fill_we_active", 32'(imem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("fill_async_we", 32'(imem_we), 32'd0);
    checkOutput("fill_async_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
